// File: rtl/branch_predict_resolve.sv
// Branch resolution unit with a per-PC 2-bit saturating direction predictor.
// Lookup is in fetch; compare, training and the mispredict pulse come from decode.
module branch_predict_resolve #(
  parameter int         DATA_W   = 32,
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pred_pc_i,
  output logic              pred_taken_o,
  input  logic              res_valid_i,
  input  logic              stall_i,
  input  logic [31:0]       res_pc_i,
  input  logic [5:0]        res_op_i,
  input  logic [DATA_W-1:0] res_a_i,
  input  logic [DATA_W-1:0] res_b_i,
  input  logic              res_pred_i,
  output logic              res_taken_o,
  output logic              mispredict_o,
  output logic              mispredict_taken_o,
  output logic [31:0]       br_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  // Branch control codes as carried on the decode control bus
  localparam logic [5:0] BEQ_CONTROL    = 6'd1;
  localparam logic [5:0] BNE_CONTROL    = 6'd2;
  localparam logic [5:0] BGTZ_CONTROL   = 6'd3;
  localparam logic [5:0] BLEZ_CONTROL   = 6'd4;
  localparam logic [5:0] BLTZ_CONTROL   = 6'd5;
  localparam logic [5:0] BLTZAL_CONTROL = 6'd6;
  localparam logic [5:0] BGEZ_CONTROL   = 6'd7;
  localparam logic [5:0] BGEZAL_CONTROL = 6'd8;

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       cnt_tab [DEPTH];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic [1:0]       cnt_cur;
  logic [1:0]       cnt_next;
  logic             a_neg;
  logic             a_zero;
  logic             a_eq_b;
  logic             is_branch;
  logic             taken;
  logic             fire;
  logic             miss;
  logic             unused_pc_bits;

  assign pred_idx       = pred_pc_i[IDX_W+1:2];
  assign res_idx        = res_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0],
                            res_pc_i[31:IDX_W+2], res_pc_i[1:0]};

  // No bypass: a same-cycle update to this index shows up next cycle
  assign pred_taken_o = cnt_tab[pred_idx][1];

  assign a_neg  = res_a_i[DATA_W-1];
  assign a_zero = (res_a_i == '0);
  assign a_eq_b = (res_a_i == res_b_i);

  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    case (res_op_i)
      BEQ_CONTROL:    taken = a_eq_b;
      BNE_CONTROL:    taken = ~a_eq_b;
      BGTZ_CONTROL:   taken = ~a_neg & ~a_zero;
      BLEZ_CONTROL:   taken = a_neg | a_zero;
      BLTZ_CONTROL,
      BLTZAL_CONTROL: taken = a_neg;
      BGEZ_CONTROL,
      BGEZAL_CONTROL: taken = ~a_neg;
      default:        is_branch = 1'b0;
    endcase
  end

  assign res_taken_o = taken;
  assign fire        = res_valid_i & ~stall_i & is_branch;
  assign miss        = taken ^ res_pred_i;

  assign cnt_cur = cnt_tab[res_idx];

  always_comb begin
    cnt_next = cnt_cur;
    if (taken && cnt_cur != 2'b11)
      cnt_next = cnt_cur + 2'b01;
    else if (!taken && cnt_cur != 2'b00)
      cnt_next = cnt_cur - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        cnt_tab[i] <= INIT_CNT;
      mispredict_o       <= 1'b0;
      mispredict_taken_o <= 1'b0;
      br_cnt_o           <= '0;
      miss_cnt_o         <= '0;
    end else begin
      mispredict_o <= fire & miss;
      if (fire) begin
        cnt_tab[res_idx]   <= cnt_next;
        mispredict_taken_o <= taken;
        if (br_cnt_o != 32'hFFFF_FFFF)
          br_cnt_o <= br_cnt_o + 32'd1;
        if (miss && miss_cnt_o != 32'hFFFF_FFFF)
          miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench for branch_predict_resolve: directed plan plus random traffic
// checked against a table-of-integers reference model.
module tb_branch_predict_resolve;

  localparam logic [5:0] OP_BEQ    = 6'd1;
  localparam logic [5:0] OP_BNE    = 6'd2;
  localparam logic [5:0] OP_BGTZ   = 6'd3;
  localparam logic [5:0] OP_BLEZ   = 6'd4;
  localparam logic [5:0] OP_BLTZ   = 6'd5;
  localparam logic [5:0] OP_BLTZAL = 6'd6;
  localparam logic [5:0] OP_BGEZ   = 6'd7;
  localparam logic [5:0] OP_BGEZAL = 6'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc_i;
  logic        pred_taken_o;
  logic        res_valid_i;
  logic        stall_i;
  logic [31:0] res_pc_i;
  logic [5:0]  res_op_i;
  logic [31:0] res_a_i;
  logic [31:0] res_b_i;
  logic        res_pred_i;
  logic        res_taken_o;
  logic        mispredict_o;
  logic        mispredict_taken_o;
  logic [31:0] br_cnt_o;
  logic [31:0] miss_cnt_o;

  branch_predict_resolve #(.DATA_W(32), .IDX_W(6), .INIT_CNT(2'b01)) dut (
    .clk(clk), .rst(rst),
    .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
    .res_valid_i(res_valid_i), .stall_i(stall_i),
    .res_pc_i(res_pc_i), .res_op_i(res_op_i),
    .res_a_i(res_a_i), .res_b_i(res_b_i), .res_pred_i(res_pred_i),
    .res_taken_o(res_taken_o), .mispredict_o(mispredict_o),
    .mispredict_taken_o(mispredict_taken_o),
    .br_cnt_o(br_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          res_taken;
    bit          pred_taken;
    bit          mis;
    bit          mt;
    logic [31:0] br;
    logic [31:0] miss;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   stim_done = 0;

  // Reference model: counters as plain integers 0..3, statistics as wide ints
  int      m_tab[64];
  bit      m_known = 0;
  bit      m_mis, m_mt;
  longint  m_br, m_miss;

  function automatic bit ref_is_branch(input logic [5:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEZAL);
  endfunction

  function automatic bit ref_taken(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    sa = $signed(a);
    case (op)
      OP_BEQ:              return a == b;
      OP_BNE:              return a != b;
      OP_BGTZ:             return sa > 0;
      OP_BLEZ:             return sa <= 0;
      OP_BLTZ, OP_BLTZAL:  return sa < 0;
      OP_BGEZ, OP_BGEZAL:  return sa >= 0;
      default:             return 0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One decode/fetch cycle: drive, enqueue expectations, advance the model
  task automatic cyc(input bit r, input bit v, input bit s, input logic [31:0] pc,
                     input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input bit pred, input logic [31:0] ppc);
    rec_t rec;
    bit   t, f;
    rst = r; res_valid_i = v; stall_i = s; res_pc_i = pc; res_op_i = op;
    res_a_i = a; res_b_i = b; res_pred_i = pred; pred_pc_i = ppc;
    t = ref_taken(op, a, b);
    f = v && !s && ref_is_branch(op);
    rec.chk        = m_known;
    rec.res_taken  = t;
    rec.pred_taken = m_known ? (m_tab[idx_of(ppc)] >= 2) : 1'b0;
    rec.mis        = m_mis;
    rec.mt         = m_mt;
    rec.br         = m_br[31:0];
    rec.miss       = m_miss[31:0];
    exp_q.push_back(rec);
    if (r) begin
      foreach (m_tab[i]) m_tab[i] = 1;
      m_mis = 0; m_mt = 0; m_br = 0; m_miss = 0; m_known = 1;
    end else begin
      m_mis = f && (t != pred);
      if (f) begin
        m_mt = t;
        if (t) m_tab[idx_of(pc)] = (m_tab[idx_of(pc)] == 3) ? 3 : m_tab[idx_of(pc)] + 1;
        else   m_tab[idx_of(pc)] = (m_tab[idx_of(pc)] == 0) ? 0 : m_tab[idx_of(pc)] - 1;
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (t != pred && m_miss < 64'hFFFF_FFFF) m_miss++;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [31:0] ppc);
    cyc(0, 0, 0, 32'h0, 6'h0, 32'h0, 32'h0, 0, ppc);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one expectation per driven cycle, sampled mid-cycle
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        if (r.chk) begin
          check("res_taken", {31'b0, res_taken_o}, {31'b0, r.res_taken});
          check("pred_taken", {31'b0, pred_taken_o}, {31'b0, r.pred_taken});
          check("mispredict", {31'b0, mispredict_o}, {31'b0, r.mis});
          check("mispredict_taken", {31'b0, mispredict_taken_o}, {31'b0, r.mt});
          check("br_cnt", br_cnt_o, r.br);
          check("miss_cnt", miss_cnt_o, r.miss);
        end
      end
    end
  end

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0110;
  localparam logic [31:0] PC_C = 32'h0040_0020;

  initial begin
    logic [31:0] pcs [4];
    rst = 1; res_valid_i = 0; stall_i = 0; res_pc_i = 0; res_op_i = 0;
    res_a_i = 0; res_b_i = 0; res_pred_i = 0; pred_pc_i = 0;
    @(posedge clk);
    #2;

    cyc(1, 0, 0, 0, 6'h0, 0, 0, 0, PC_A);
    cyc(1, 0, 0, 0, 6'h0, 0, 0, 0, PC_A);
    idle(PC_A);

    cyc(0, 1, 0, PC_A, OP_BEQ, 5, 5, 0, PC_A);
    cyc(0, 1, 0, PC_A, OP_BEQ, 5, 5, 0, PC_A);
    idle(PC_A);
    idle(PC_A);

    cyc(0, 1, 0, PC_C, OP_BGTZ,   32'h0,         0, 0, PC_C);
    cyc(0, 1, 0, PC_C, OP_BGTZ,   32'h8000_0000, 0, 1, PC_C);
    cyc(0, 1, 0, PC_C, OP_BLEZ,   32'h0,         0, 0, PC_C);
    cyc(0, 1, 0, PC_C, OP_BGEZAL, 32'h7FFF_FFFF, 0, 1, PC_C);
    cyc(0, 1, 0, PC_C, OP_BLTZ,   32'hFFFF_FFFF, 0, 0, PC_C);
    idle(PC_C);

    for (int i = 0; i < 5; i++) cyc(0, 1, 0, PC_A, OP_BEQ, 7, 7, 1, PC_A);
    cyc(0, 1, 0, PC_B, OP_BNE, 3, 3, 1, PC_A);
    idle(PC_A);
    cyc(0, 1, 0, PC_B, OP_BNE, 3, 3, 1, PC_A);
    idle(PC_A);

    for (int i = 0; i < 3; i++) cyc(0, 1, 1, PC_C, OP_BNE, 1, 2, 0, PC_C);
    cyc(0, 1, 0, PC_C, OP_BNE, 1, 2, 0, PC_C);
    idle(PC_C);
    cyc(0, 1, 0, PC_C, 6'h3F, 1, 2, 0, PC_C);
    idle(PC_C);

    cyc(0, 1, 0, PC_A, OP_BNE, 1, 2, 0, PC_A);
    cyc(1, 0, 0, 0, 6'h0, 0, 0, 0, PC_A);
    idle(PC_A);
    cyc(1, 1, 0, PC_A, OP_BNE, 1, 2, 0, PC_A);
    idle(PC_A);
    for (int i = 0; i < 2; i++) cyc(0, 1, 0, PC_B, OP_BEQ, 9, 9, 1, PC_A);
    idle(PC_A);

    pcs[0] = PC_A; pcs[1] = PC_B; pcs[2] = PC_C; pcs[3] = 32'h0040_0024;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b, rpc;
      logic [5:0]  op;
      a   = pick_val();
      b   = ($urandom_range(0, 1) == 1) ? a : pick_val();
      op  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 8));
      rpc = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 3)];
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
          rpc, op, a, b, 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 3)]);
    end
    idle(PC_A);
    stim_done = 1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
